// File: rtl/wave_sched_pkg.sv
// rtl/wave_sched_pkg.sv - shared constants, types and helpers for the wave source scheduler
//
// Purpose: common widths, request encoding, FSM state type and the clip divide helper
// used by wave_source_scheduler and switch_debouncer.
// Ports: none (package).

package wave_sched_pkg;

  localparam int N_SRC   = 4;
  localparam int DUTY_W  = 7;
  localparam int PWM_W   = 6;
  localparam int DEB_CYC = 16;
  localparam int SRC_W   = 2;
  localparam int CLIP_W  = 3;

  localparam logic [DUTY_W-1:0] DUTY_MAX = 7'd64;
  localparam logic [CLIP_W-1:0] CLIP_MIN = 3'd1;
  localparam logic [CLIP_W-1:0] CLIP_MAX = 3'd7;

  // Arbiter result: none=1 means no accepted-enabled source.
  typedef struct packed {
    logic             none;
    logic [SRC_W-1:0] idx;
  } req_t;

  localparam req_t SRC_NONE = '{none: 1'b1, idx: 2'd0};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  // Truncating divide by the clip factor, then saturate to full-scale duty.
  // div is never 0 because the clip factor cycles 1..7.
  function automatic logic [DUTY_W-1:0] clip_duty(input logic [DUTY_W-1:0] duty,
                                                  input logic [CLIP_W-1:0] div);
    logic [DUTY_W-1:0] q;
    q = duty / {4'd0, div};
    return (q > DUTY_MAX) ? DUTY_MAX : q;
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - two-flop synchroniser plus stable-count debouncer for one switch
//
// Purpose: accepts a new switch level only after it has been seen at the synchronised
// output for CYC consecutive cycles. Raw edge to accepted level = 2 + CYC cycles.
// Ports:
//   sysclk    in  clock
//   rst_n     in  asynchronous active-low reset (accepted level resets to 0)
//   sw_raw    in  raw asynchronous switch level
//   sw_level  out debounced, accepted switch level

module switch_debouncer
  import wave_sched_pkg::*;
#(
  parameter int CYC = DEB_CYC
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic sw_raw,
  output logic sw_level
);

  localparam int CNT_W = $clog2(CYC + 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = sw_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    // Count consecutive cycles that disagree with the accepted level; any
    // agreeing cycle restarts the count, so bounce never gets through.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(CYC - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sw_level = level_q;

endmodule

// File: rtl/wave_source_scheduler.sv
// rtl/wave_source_scheduler.sv - source arbitration, clip and 64-step PWM generation
//
// Purpose: picks the lowest-index debounced-enabled duty source, divides its duty by
// the user clip factor and drives a glitch-free PWM; all source, duty and clip
// changes land on a frame boundary.
// Ports:
//   sysclk       in  clock
//   rst_n        in  asynchronous active-low reset
//   sw_en        in  raw source enable switches, one per source
//   duty_in      in  packed source duties, source i at [i*7 +: 7]
//   clip_step    in  one-cycle pulse advancing the clip factor at the next boundary
//   src_valid    out a source is driving the PWM
//   active_src   out index of the driving source (0 when !src_valid)
//   clip_factor  out current divisor, 1..7
//   duty_out     out duty latched for the current frame
//   frame_tick   out high in the last cycle of each frame (pwm count 63)
//   pwm_out      out registered PWM pulse

module wave_source_scheduler
  import wave_sched_pkg::*;
(
  input  logic                    sysclk,
  input  logic                    rst_n,
  input  logic [N_SRC-1:0]        sw_en,
  input  logic [N_SRC*DUTY_W-1:0] duty_in,
  input  logic                    clip_step,
  output logic                    src_valid,
  output logic [SRC_W-1:0]        active_src,
  output logic [CLIP_W-1:0]       clip_factor,
  output logic [DUTY_W-1:0]       duty_out,
  output logic                    frame_tick,
  output logic                    pwm_out
);

  logic [N_SRC-1:0]  sw_acc;
  logic [DUTY_W-1:0] duty_arr [N_SRC];

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
    switch_debouncer #(.CYC(DEB_CYC)) u_deb (
      .sysclk   (sysclk),
      .rst_n    (rst_n),
      .sw_raw   (sw_en[gi]),
      .sw_level (sw_acc[gi])
    );
    assign duty_arr[gi] = duty_in[gi*DUTY_W +: DUTY_W];
  end

  // Fixed priority: scanning downward leaves the lowest enabled index.
  req_t req;
  always_comb begin
    req = SRC_NONE;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (sw_acc[i]) req = '{none: 1'b0, idx: SRC_W'(i)};
    end
  end

  logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic              frame_tick_q, frame_tick_d;
  state_e            state_q, state_d;
  logic              src_valid_q, src_valid_d;
  logic [SRC_W-1:0]  active_src_q, active_src_d;
  logic [CLIP_W-1:0] clip_q, clip_d;
  logic              clip_pend_q, clip_pend_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              pwm_q, pwm_d;

  always_comb begin
    pwm_cnt_d    = pwm_cnt_q + PWM_W'(1);
    // Registered tick lines up with the cycle where the count reads 63.
    frame_tick_d = (pwm_cnt_d == '1);

    state_d      = state_q;
    src_valid_d  = src_valid_q;
    active_src_d = active_src_q;

    case (state_q)
      IDLE: begin
        if (!req.none) state_d = PEND;
      end
      RUN: begin
        if (req.none || (req.idx != active_src_q)) state_d = PEND;
      end
      PEND: begin
        if (frame_tick_q) begin
          if (req.none) begin
            state_d      = IDLE;
            src_valid_d  = 1'b0;
            active_src_d = '0;
          end else begin
            state_d      = RUN;
            src_valid_d  = 1'b1;
            active_src_d = req.idx;
          end
        end else if (src_valid_q && !req.none && (req.idx == active_src_q)) begin
          // Request bounced back to the running source: nothing to change.
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pulses collapse into one pending step; a pulse in the tick cycle itself
    // is honoured at that same boundary.
    clip_d      = clip_q;
    clip_pend_d = clip_pend_q | clip_step;
    if (frame_tick_q) begin
      clip_pend_d = 1'b0;
      if (clip_pend_q || clip_step) begin
        clip_d = (clip_q == CLIP_MAX) ? CLIP_MIN : clip_q + CLIP_W'(1);
      end
    end

    duty_d = duty_q;
    if (frame_tick_q) begin
      duty_d = src_valid_d ? clip_duty(duty_arr[active_src_d], clip_d) : '0;
    end

    // Uses next-cycle count and duty so the new frame's duty applies from count 0.
    pwm_d = ({1'b0, pwm_cnt_d} < duty_d);
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q    <= '0;
      frame_tick_q <= 1'b0;
      state_q      <= IDLE;
      src_valid_q  <= 1'b0;
      active_src_q <= '0;
      clip_q       <= CLIP_MIN;
      clip_pend_q  <= 1'b0;
      duty_q       <= '0;
      pwm_q        <= 1'b0;
    end else begin
      pwm_cnt_q    <= pwm_cnt_d;
      frame_tick_q <= frame_tick_d;
      state_q      <= state_d;
      src_valid_q  <= src_valid_d;
      active_src_q <= active_src_d;
      clip_q       <= clip_d;
      clip_pend_q  <= clip_pend_d;
      duty_q       <= duty_d;
      pwm_q        <= pwm_d;
    end
  end

  assign src_valid   = src_valid_q;
  assign active_src  = active_src_q;
  assign clip_factor = clip_q;
  assign duty_out    = duty_q;
  assign frame_tick  = frame_tick_q;
  assign pwm_out     = pwm_q;

endmodule

// File: tb/tb_wave_source_scheduler.sv
// tb/tb_wave_source_scheduler.sv - self-checking frame scoreboard bench for wave_source_scheduler

module tb_wave_source_scheduler;
  import wave_sched_pkg::*;

  logic        sysclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  sw_en = '0;
  logic [27:0] duty_in = '0;
  logic        clip_step = 1'b0;
  logic        src_valid;
  logic [1:0]  active_src;
  logic [2:0]  clip_factor;
  logic [6:0]  duty_out;
  logic        frame_tick;
  logic        pwm_out;

  wave_source_scheduler dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .sw_en       (sw_en),
    .duty_in     (duty_in),
    .clip_step   (clip_step),
    .src_valid   (src_valid),
    .active_src  (active_src),
    .clip_factor (clip_factor),
    .duty_out    (duty_out),
    .frame_tick  (frame_tick),
    .pwm_out     (pwm_out)
  );

  always #5 sysclk = ~sysclk;

  typedef struct packed {
    logic       sv;
    logic [1:0] src;
    logic [6:0] duty;
    logic [2:0] clip;
    logic [6:0] hi;
    logic       held_ok;
  } frame_t;

  frame_t exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  function automatic frame_t mk(input logic sv, input int src, input int duty,
                                input int clip, input int hi);
    return '{sv: sv, src: 2'(src), duty: 7'(duty), clip: 3'(clip), hi: 7'(hi), held_ok: 1'b1};
  endfunction

  function automatic string fstr(input frame_t f);
    return $sformatf("sv=%0d src=%0d duty=%0d clip=%0d high=%0d held=%0d",
                     f.sv, f.src, f.duty, f.clip, f.hi, f.held_ok);
  endfunction

  task automatic set_duty(input int i, input int d);
    duty_in[i*7 +: 7] = 7'(d);
  endtask

  task automatic pulse_clip();
    clip_step = 1'b1;
    @(negedge sysclk);
    clip_step = 1'b0;
  endtask

  // Called at a frame start (just after the wrap edge); returns after the next wrap edge.
  task automatic measure_frame(output frame_t f);
    int hi;
    logic ok;
    hi = 0;
    ok = 1'b1;
    f = '0;
    for (int i = 0; i < 64; i++) begin
      @(negedge sysclk);
      if (i == 0) begin
        f.sv = src_valid; f.src = active_src; f.duty = duty_out; f.clip = clip_factor;
      end else if (src_valid !== f.sv || active_src !== f.src ||
                   duty_out !== f.duty || clip_factor !== f.clip) begin
        ok = 1'b0;
      end
      if (pwm_out === 1'b1) hi++;
      if (frame_tick !== (i == 63)) ok = 1'b0;
    end
    f.hi = 7'(hi);
    f.held_ok = ok;
    @(posedge sysclk);
  endtask

  task automatic sync_frame(input string tag);
    int n;
    @(negedge sysclk);
    n = 1;
    while (frame_tick !== 1'b1 && n < 200) begin
      @(negedge sysclk);
      n++;
    end
    if (frame_tick !== 1'b1) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_sync: frame_tick not seen within %0d cycles, required within 64", tag, n);
    end
    @(posedge sysclk);
  endtask

  task automatic test_reset();
    frame_t obs, e;
    rst_n = 1'b0; sw_en = '0; duty_in = '0; clip_step = 1'b0;
    repeat (3) @(negedge sysclk);
    n_cmp++;
    if ({src_valid, active_src, clip_factor, duty_out, frame_tick, pwm_out} !==
        {1'b0, 2'd0, 3'd1, 7'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got sv=%0d src=%0d clip=%0d duty=%0d tick=%0d pwm=%0d, required 0 0 1 0 0 0",
               src_valid, active_src, clip_factor, duty_out, frame_tick, pwm_out);
    end
    rst_n = 1'b1;
    sync_frame("reset");
    repeat (2) exp_q.push_back(mk(0, 0, 0, 1, 0));
    for (int f = 0; f < 2; f++) begin
      measure_frame(obs);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset_idle_frame%0d: got %s, required %s", f, fstr(obs), fstr(e));
      end
    end
  endtask

  task automatic test_full_duty();
    frame_t obs, e;
    #1;
    sw_en = 4'b0001;
    set_duty(0, 64);
    exp_q.push_back(mk(0, 0, 0, 1, 0));
    exp_q.push_back(mk(1, 0, 64, 1, 64));
    exp_q.push_back(mk(1, 0, 64, 1, 64));
    for (int f = 0; f < 3; f++) begin
      measure_frame(obs);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL full_duty_frame%0d: got %s, required %s", f, fstr(obs), fstr(e));
      end
    end
  endtask

  task automatic test_priority_switch();
    frame_t obs, e;
    #1;
    set_duty(0, 32);
    set_duty(2, 10);
    sw_en = 4'b0101;
    exp_q.push_back(mk(1, 0, 64, 1, 64));
    exp_q.push_back(mk(1, 0, 32, 1, 32));
    for (int f = 0; f < 2; f++) begin
      measure_frame(obs);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL priority_frame%0d: got %s, required %s", f, fstr(obs), fstr(e));
      end
    end
    #1;
    sw_en = 4'b0100;
    exp_q.push_back(mk(1, 0, 32, 1, 32));
    exp_q.push_back(mk(1, 2, 10, 1, 10));
    for (int f = 0; f < 2; f++) begin
      measure_frame(obs);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL drop_sw0_frame%0d: got %s, required %s", f, fstr(obs), fstr(e));
      end
    end
  endtask

  task automatic test_bounce();
    frame_t obs, e;
    repeat (2) exp_q.push_back(mk(1, 2, 10, 1, 10));
    fork
      begin
        for (int t = 0; t < 20; t++) begin
          repeat (5) @(negedge sysclk);
          sw_en[1] = ~sw_en[1];
        end
      end
      begin
        for (int f = 0; f < 2; f++) begin
          measure_frame(obs);
          e = exp_q.pop_front();
          n_cmp++;
          if (obs !== e) begin
            n_fail++;
            $display("FAIL bounce_frame%0d: got %s, required %s", f, fstr(obs), fstr(e));
          end
        end
      end
    join
  endtask

  task automatic test_clip();
    frame_t obs, e;
    int clip_m;
    logic stepped;
    clip_m = 1;
    #1;
    set_duty(2, 63);
    for (int f = 0; f < 10; f++) begin
      stepped = (f <= 6) || (f == 8);
      exp_q.push_back(mk(1, 2, (f == 0) ? 10 : 63 / clip_m, clip_m, (f == 0) ? 10 : 63 / clip_m));
      fork
        measure_frame(obs);
        begin
          if (f == 0) begin
            repeat (3) begin
              repeat (5) @(negedge sysclk);
              pulse_clip();
            end
          end else if (f <= 6) begin
            repeat (10) @(negedge sysclk);
            pulse_clip();
          end else if (f == 8) begin
            repeat (64) @(negedge sysclk);
            clip_step = 1'b1;
            @(posedge sysclk);
            #1 clip_step = 1'b0;
          end
        end
      join
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL clip_frame%0d: got %s, required %s", f, fstr(obs), fstr(e));
      end
      if (stepped) clip_m = (clip_m == 7) ? 1 : clip_m + 1;
    end
  endtask

  task automatic test_reset_in_pend();
    frame_t obs, e;
    int n;
    logic early;
    #1;
    sw_en = 4'b0001;
    repeat (30) @(negedge sysclk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({src_valid, active_src, clip_factor, duty_out, frame_tick, pwm_out} !==
        {1'b0, 2'd0, 3'd1, 7'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midframe_reset: got sv=%0d src=%0d clip=%0d duty=%0d tick=%0d pwm=%0d, required 0 0 1 0 0 0",
               src_valid, active_src, clip_factor, duty_out, frame_tick, pwm_out);
    end
    repeat (3) @(negedge sysclk);
    rst_n = 1'b1;
    n = 0;
    early = 1'b0;
    do begin
      @(negedge sysclk);
      n++;
      if (src_valid !== 1'b0) early = 1'b1;
    end while (frame_tick !== 1'b1 && n < 200);
    n_cmp++;
    if (n != 63) begin
      n_fail++;
      $display("FAIL post_reset_first_tick: got tick after %0d cycles, required 63", n);
    end
    n_cmp++;
    if (early !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_latency: got src_valid=1 before first boundary, required 0");
    end
    @(posedge sysclk);
    exp_q.push_back(mk(1, 0, 32, 1, 32));
    measure_frame(obs);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL post_reset_frame: got %s, required %s", fstr(obs), fstr(e));
    end
  endtask

  initial begin
    test_reset();
    test_full_duty();
    test_priority_switch();
    test_bounce();
    test_clip();
    test_reset_in_pend();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
